// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB first over WIDTH cycles.
// Optional SERIAL_SUB_ADD_MODE_EN adds a 'mode' input that selects a + b + bin instead.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic x, y, d, br_next, last;

    assign x    = a_q[0];
    assign y    = b_q[0];
    assign d    = x ^ y ^ br_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic mode_q, mode_d;
    // Same sum bit for both modes; only the carry/borrow recurrence differs.
    assign br_next = mode_q ? ((x & y) | (br_q & (x ^ y)))
                            : ((~x & y) | (~(x ^ y) & br_q));
`else
    assign br_next = (~x & y) | (~(x ^ y) & br_q);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        mode_d  = mode_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    mode_d  = mode;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    // Publish only the complete word; partial results stay internal.
                    diff_d  = {d, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected {bout,diff} queued at start, checked on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk, rst, start, bin, mode;
    logic [W-1:0] a, b;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .mode  (mode),
`endif
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [W:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("diff", 32'(diff), 32'(e[W-1:0]));
                chk("bout", 32'(bout), 32'(e[W]));
            end
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic ibin, input logic imode);
        if (imode) return {1'b0, ia} + {1'b0, ib} + (W+1)'(ibin);
        return {1'b0, ia} - {1'b0, ib} - (W+1)'(ibin);
    endfunction

    // Drive one operation from IDLE and wait for its done pulse; checks latency and busy span.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          input logic imode, input string tag);
        int start_edge, busy_n, n0;
        bit seen;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; mode = imode; start = 1'b1;
        exp_q.push_back(model(ia, ib, ibin, imode));
        start_edge = cyc + 1;
        n0 = done_cnt;
        busy_n = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b0;
        a = '1; b = '1; bin = 1'b1; mode = ~imode;
        for (int i = 0; i < W + 6 && !seen; i++) begin
            if (done === 1'b1) seen = 1;
            else begin
                if (busy === 1'b1) busy_n++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), W);
        #1;
        chk({tag, "_latency"}, 32'(done_cyc - start_edge), W);
        chk({tag, "_one_done"}, 32'(done_cnt - n0), 32'd1);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int t[3];
        int k;
        int n0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 1'b0, 1'b0, "basic");
        run_op(8'd5, 8'd9, 1'b0, 1'b0, "underflow");
        run_op(8'd0, 8'd0, 1'b1, 1'b0, "zero_bin");
        run_op(8'd255, 8'd255, 1'b0, 1'b0, "equal");
        for (int i = 0; i < 4; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");

        // Start pulsed again mid-SHIFT must be ignored.
        @(negedge clk);
        a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'd50, 8'd20, 1'b0, 1'b0));
        n0 = done_cnt;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("ignore_one_done", 32'(done_cnt - n0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ignore_hold_diff", 32'(diff), 32'd30);
        end

        // Reset on the 4th SHIFT edge aborts the operation.
        @(negedge clk);
        a = 8'd200; b = 8'd1; bin = 1'b0; start = 1'b1;
        n0 = done_cnt;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        repeat (W + 6) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - n0), 32'd0);

        // start held high: three operations, WIDTH+2 cycles apart.
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'd10, 8'd3, 1'b0, 1'b0));
        @(negedge clk);
        a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t[k] = cyc;
                k++;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            chk("b2b_period1", 32'(t[1] - t[0]), W + 2);
            chk("b2b_period2", 32'(t[2] - t[1]), W + 2);
        end
        repeat (W + 4) @(negedge clk);

`ifdef SERIAL_SUB_ADD_MODE_EN
        run_op(8'd200, 8'd100, 1'b0, 1'b1, "add_carry");
        run_op(8'd7, 8'd8, 1'b1, 1'b1, "add_small");
        run_op(8'd7, 8'd8, 1'b1, 1'b0, "sub_after_add");
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
